fifo_param: RTL and testbench

- Synchronous single-clock FIFO; parametrised successor to the fixed 8-bit FIFO.
- Adds the following to the basic FIFO:
  - generic width and depth
  - first-word-fall-through (FWFT) mode
  - almost-full / almost-empty thresholds
  - an occupancy count
  - synchronous flush
  - sticky overflow / underflow error flags
- Sits between producer and consumer blocks in the same clock domain.
- Drop-in superset of the existing read_en / write_en / data_in / data_outp / fifo_full / fifo_empty interface.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/fifo_param.sv | 151 +++++++++++++++
 tb/tb_fifo_param.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the parametrised FIFO.
package fifo_pkg;

    typedef enum logic {
        MODE_STD,
        MODE_FWFT
    } read_mode_t;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: synchronous write port, asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_W-1:0]     i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_W-1:0]     i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fifo_param.sv
// Single-clock FIFO with thresholds, occupancy count, flush,
// sticky error flags and optional first-word-fall-through read.
module fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    parameter int FWFT          = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     err_clear,
    input  logic                     write_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     read_en,
    output logic [DATA_WIDTH-1:0]    data_outp,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [cnt_w(DEPTH)-1:0]  fill_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam read_mode_t MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_param: DEPTH must be a power of 2 and >= 2");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_param: AFULL_THRESH out of range 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_param: AEMPTY_THRESH out of range 0..DEPTH-1");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("fifo_param: DATA_WIDTH must be >= 1");
    end

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_full;
    logic                  r_empty;
    logic                  r_afull;
    logic                  r_aempty;
    logic                  r_ovf;
    logic                  r_udf;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    logic                  w_rd_go;
    logic                  w_wr_go;
    logic                  w_ovf_set;
    logic                  w_udf_set;
    logic [DATA_WIDTH-1:0] w_rd_data;

    assign w_rd_acc  = read_en & ~r_empty;
    assign w_wr_acc  = write_en & (~r_full | w_rd_acc);
    // flush overrides both ports and suppresses error reporting
    assign w_rd_go   = w_rd_acc & ~flush;
    assign w_wr_go   = w_wr_acc & ~flush;
    assign w_ovf_set = write_en & ~w_wr_acc & ~flush;
    assign w_udf_set = read_en & r_empty & ~flush;

    always_comb begin
        w_cnt_nxt = r_count;
        if (flush) begin
            w_cnt_nxt = '0;
        end else begin
            unique case ({w_wr_go, w_rd_go})
                2'b10:   w_cnt_nxt = r_count + CNT_W'(1);
                2'b01:   w_cnt_nxt = r_count - CNT_W'(1);
                default: w_cnt_nxt = r_count;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_afull  <= 1'b0;
            r_aempty <= 1'b1;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_go) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_rd_go) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count  <= w_cnt_nxt;
            r_full   <= (w_cnt_nxt == CNT_W'(DEPTH));
            r_empty  <= (w_cnt_nxt == '0);
            r_afull  <= (w_cnt_nxt >= CNT_W'(AFULL_THRESH));
            r_aempty <= (w_cnt_nxt <= CNT_W'(AEMPTY_THRESH));
            r_ovf    <= w_ovf_set | (r_ovf & ~err_clear);
            r_udf    <= w_udf_set | (r_udf & ~err_clear);
        end
    end

    fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (PTR_W)
    ) u_mem (
        .i_clk   (clock),
        .i_we    (w_wr_go),
        .i_waddr (r_wr_ptr),
        .i_wdata (data_in),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    if (MODE == MODE_STD) begin : g_std
        logic [DATA_WIDTH-1:0] r_dout;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                r_dout <= '0;
            end else if (w_rd_go) begin
                r_dout <= w_rd_data;
            end
        end

        assign data_outp = r_dout;
    end else begin : g_fwft
        assign data_outp = w_rd_data;
    end

    assign fifo_full    = r_full;
    assign fifo_empty   = r_empty;
    assign almost_full  = r_afull;
    assign almost_empty = r_aempty;
    assign fill_count   = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: a standard-read and an FWFT instance share one
// stimulus stream and are compared against a queue-based model.
module tb_fifo_param;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       err_clear = 1'b0;
    logic       write_en = 1'b0;
    logic       read_en = 1'b0;
    logic [7:0] data_in = '0;

    logic [7:0] s_dout, f_dout;
    logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_udf;
    logic       f_full, f_empty, f_afull, f_aempty, f_ovf, f_udf;
    logic [4:0] s_cnt, f_cnt;
    logic [10:0] st_s, st_f;

    int n_pass = 0;
    int n_total = 0;

    logic [7:0] q[$];
    logic [7:0] m_dout = '0;
    bit         m_ovf = 1'b0;
    bit         m_udf = 1'b0;

    always #5 clock = ~clock;

    fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clock(clock), .reset(reset), .flush(flush), .err_clear(err_clear),
        .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_outp(s_dout), .fifo_full(s_full), .fifo_empty(s_empty),
        .almost_full(s_afull), .almost_empty(s_aempty), .fill_count(s_cnt),
        .overflow(s_ovf), .underflow(s_udf)
    );

    fifo_param #(.DATA_WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clock(clock), .reset(reset), .flush(flush), .err_clear(err_clear),
        .write_en(write_en), .data_in(data_in), .read_en(read_en),
        .data_outp(f_dout), .fifo_full(f_full), .fifo_empty(f_empty),
        .almost_full(f_afull), .almost_empty(f_aempty), .fill_count(f_cnt),
        .overflow(f_ovf), .underflow(f_udf)
    );

    assign st_s = {s_full, s_empty, s_afull, s_aempty, s_cnt, s_ovf, s_udf};
    assign st_f = {f_full, f_empty, f_afull, f_aempty, f_cnt, f_ovf, f_udf};

    // {full, empty, afull(>=14), aempty(<=2), count, ovf, udf}
    function automatic logic [10:0] exp_st();
        int n;
        n = q.size();
        return {n == 16, n == 0, n >= 14, n <= 2, 5'(n), m_ovf, m_udf};
    endfunction

    task automatic mreset();
        q.delete();
        m_dout = '0;
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic step(input bit we, input logic [7:0] d, input bit re,
                        input bit fl, input bit ec);
        bit emp, ful, racc, wacc;
        write_en = we;
        data_in = d;
        read_en = re;
        flush = fl;
        err_clear = ec;
        @(posedge clock);
        emp = (q.size() == 0);
        ful = (q.size() == 16);
        racc = re && !emp;
        wacc = we && (!ful || racc);
        if (fl) begin
            q.delete();
        end else begin
            if (racc) m_dout = q.pop_front();
            if (wacc) q.push_back(d);
        end
        m_ovf = (m_ovf && !ec) || (!fl && we && !wacc);
        m_udf = (m_udf && !ec) || (!fl && re && emp);
        #1;
        write_en = 1'b0;
        read_en = 1'b0;
        flush = 1'b0;
        err_clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        mreset();
        repeat (2) @(posedge clock);
        #1;
        n_total++;
        if (st_s !== exp_st()) $display("FAIL reset_std got %h want %h", st_s, exp_st());
        else n_pass++;
        n_total++;
        if (st_f !== exp_st()) $display("FAIL reset_fwft got %h want %h", st_f, exp_st());
        else n_pass++;
        n_total++;
        if (s_dout !== 8'h00) $display("FAIL reset_dout got %h want 00", s_dout);
        else n_pass++;
        reset = 1'b1;
        step(0, 8'h00, 0, 0, 0);
        n_total++;
        if (st_s !== exp_st()) $display("FAIL idle_std got %h want %h", st_s, exp_st());
        else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 16; i++) begin
            step(1, 8'(i), 0, 0, 0);
            n_total++;
            if (st_s !== exp_st()) $display("FAIL fill_std[%0d] got %h want %h", i, st_s, exp_st());
            else n_pass++;
            n_total++;
            if (st_f !== exp_st()) $display("FAIL fill_fwft[%0d] got %h want %h", i, st_f, exp_st());
            else n_pass++;
        end
        for (int i = 1; i <= 16; i++) begin
            n_total++;
            if (f_dout !== 8'(i)) $display("FAIL drain_fwft[%0d] got %h want %h", i, f_dout, 8'(i));
            else n_pass++;
            step(0, 8'h00, 1, 0, 0);
            n_total++;
            if (s_dout !== 8'(i)) $display("FAIL drain_std[%0d] got %h want %h", i, s_dout, 8'(i));
            else n_pass++;
            n_total++;
            if (st_s !== exp_st()) $display("FAIL drain_st[%0d] got %h want %h", i, st_s, exp_st());
            else n_pass++;
        end
        step(0, 8'h00, 0, 0, 0);
        n_total++;
        if (s_dout !== 8'h10) $display("FAIL hold_empty got %h want 10", s_dout);
        else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) step(1, 8'($urandom), 0, 0, 0);
        step(1, 8'hEE, 0, 0, 0);
        n_total++;
        if (st_s !== exp_st() || !s_ovf) $display("FAIL ovf_set got %h want %h", st_s, exp_st());
        else n_pass++;
        n_total++;
        if (s_dout !== m_dout) $display("FAIL ovf_dout got %h want %h", s_dout, m_dout);
        else n_pass++;
        step(1, 8'hAA, 1, 0, 0);
        n_total++;
        if (st_s !== exp_st() || s_cnt !== 5'd16) $display("FAIL full_rw got %h want %h", st_s, exp_st());
        else n_pass++;
        step(0, 8'h00, 0, 0, 1);
        n_total++;
        if (st_f !== exp_st() || f_ovf) $display("FAIL ovf_clear got %h want %h", st_f, exp_st());
        else n_pass++;
        for (int i = 0; i < 16; i++) begin
            step(0, 8'h00, 1, 0, 0);
            n_total++;
            if (s_dout !== m_dout) $display("FAIL ovf_drain[%0d] got %h want %h", i, s_dout, m_dout);
            else n_pass++;
        end
        n_total++;
        if (s_dout !== 8'hAA) $display("FAIL ovf_last got %h want aa", s_dout);
        else n_pass++;
    endtask

    task automatic test_underflow();
        step(0, 8'h00, 1, 0, 0);
        n_total++;
        if (st_s !== exp_st() || !s_udf) $display("FAIL udf_set got %h want %h", st_s, exp_st());
        else n_pass++;
        n_total++;
        if (s_dout !== 8'hAA) $display("FAIL udf_hold got %h want aa", s_dout);
        else n_pass++;
        step(1, 8'h55, 1, 0, 0);
        n_total++;
        if (st_s !== exp_st() || s_cnt !== 5'd1) $display("FAIL udf_rw got %h want %h", st_s, exp_st());
        else n_pass++;
        n_total++;
        if (f_dout !== 8'h55) $display("FAIL udf_fwft got %h want 55", f_dout);
        else n_pass++;
        step(0, 8'h00, 0, 0, 1);
        n_total++;
        if (st_f !== exp_st()) $display("FAIL udf_clear got %h want %h", st_f, exp_st());
        else n_pass++;
        step(0, 8'h00, 1, 0, 0);
        n_total++;
        if (s_dout !== 8'h55) $display("FAIL udf_read got %h want 55", s_dout);
        else n_pass++;
    endtask

    task automatic test_fwft();
        step(1, 8'h3C, 0, 0, 0);
        n_total++;
        if (f_dout !== 8'h3C || f_empty !== 1'b0) $display("FAIL fwft_fall got %h/%b want 3c/0", f_dout, f_empty);
        else n_pass++;
        step(0, 8'h00, 1, 0, 0);
        n_total++;
        if (st_f !== exp_st() || !f_empty) $display("FAIL fwft_read got %h want %h", st_f, exp_st());
        else n_pass++;
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 24; i++) begin
            step(1, 8'($urandom), i[0], 0, 0);
            n_total++;
            if (st_s !== exp_st() || st_f !== exp_st())
                $display("FAIL wrap_st[%0d] got %h/%h want %h", i, st_s, st_f, exp_st());
            else n_pass++;
            n_total++;
            if (s_dout !== m_dout || (q.size() != 0 && f_dout !== q[0]))
                $display("FAIL wrap_data[%0d] got %h/%h want %h", i, s_dout, f_dout, m_dout);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        logic [7:0] held;
        held = s_dout;
        step(1, 8'h77, 1, 1, 0);
        n_total++;
        if (st_s !== exp_st() || s_cnt !== 5'd0) $display("FAIL flush_st got %h want %h", st_s, exp_st());
        else n_pass++;
        n_total++;
        if (s_dout !== held) $display("FAIL flush_dout got %h want %h", s_dout, held);
        else n_pass++;
        step(1, 8'h81, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        n_total++;
        if (s_dout !== 8'h81 || st_f !== exp_st()) $display("FAIL flush_after got %h want 81", s_dout);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) step(1, 8'(8'hC0 + i), i[0], 0, 0);
        write_en = 1'b1;
        data_in = 8'hFF;
        #2;
        reset = 1'b0;
        mreset();
        #1;
        n_total++;
        if (st_s !== exp_st() || st_f !== exp_st())
            $display("FAIL async_rst got %h/%h want %h", st_s, st_f, exp_st());
        else n_pass++;
        n_total++;
        if (s_dout !== 8'h00) $display("FAIL async_rst_dout got %h want 00", s_dout);
        else n_pass++;
        write_en = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        step(1, 8'h9A, 0, 0, 0);
        step(0, 8'h00, 1, 0, 0);
        n_total++;
        if (s_dout !== 8'h9A || st_s !== exp_st()) $display("FAIL post_rst got %h want 9a", s_dout);
        else n_pass++;
    endtask

    task automatic test_random();
        bit we, re, fl, ec;
        for (int i = 0; i < 400; i++) begin
            we = (i < 200) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            re = (i < 200) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
            fl = ($urandom_range(40) == 0);
            ec = ($urandom_range(15) == 0);
            step(we, 8'($urandom), re, fl, ec);
            n_total++;
            if (st_s !== exp_st() || st_f !== exp_st())
                $display("FAIL rand_st[%0d] got %h/%h want %h", i, st_s, st_f, exp_st());
            else n_pass++;
            n_total++;
            if (s_dout !== m_dout || (q.size() != 0 && f_dout !== q[0]))
                $display("FAIL rand_data[%0d] got %h/%h want %h", i, s_dout, f_dout, m_dout);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_fwft();
        test_wrap();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
